// File: rtl/button_pkg.sv
// Shared definitions for the button event classifier:
// FSM encoding, default timing and counter sizing.
package button_pkg;

   localparam int unsigned LONG_CYCLES_DEF   = 50_000_000;
   localparam int unsigned DCLICK_CYCLES_DEF = 12_500_000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRESSED,
      ST_HELD,
      ST_GAP,
      ST_SECOND
   } state_e;

   function automatic int unsigned cnt_width(
      input int unsigned a,
      input int unsigned b
   );
      int unsigned m;
      m = (a > b) ? a : b;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/edge_detect.sv
// Registers a level and flags its rising and falling edges.
// The history resets high so a level held through reset is not a rise.
module edge_detect (
   input  logic clock,
   input  logic reset,
   input  logic in,
   output logic rise,
   output logic fall
);

   logic in_d;
   logic in_q;

   always_comb begin
      in_d = in;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         in_q <= 1'b1;
      end else begin
         in_q <= in_d;
      end
   end

   assign rise = in & ~in_q;
   assign fall = ~in & in_q;

endmodule

// File: rtl/button_event.sv
// Classifies a debounced button into edge, single, double and long
// press events using one shared saturating counter.
module button_event
   import button_pkg::*;
#(
   parameter int unsigned LONG_CYCLES   = LONG_CYCLES_DEF,
   parameter int unsigned DCLICK_CYCLES = DCLICK_CYCLES_DEF
) (
   input  logic clock,
   input  logic reset,
   input  logic clean,
   output logic press_edge,
   output logic release_edge,
   output logic single_press,
   output logic double_press,
   output logic long_press,
   output logic held,
   output logic busy
);

   localparam int unsigned CW = cnt_width(LONG_CYCLES, DCLICK_CYCLES);
   localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
   localparam logic [CW-1:0] DCLK_LAST = CW'(DCLICK_CYCLES - 1);
   localparam logic [CW-1:0] CNT_MAX   = '1;

   logic          rise;
   logic          fall;
   state_e        state_d, state_q;
   logic [CW-1:0] cnt_d, cnt_q;
   logic [CW-1:0] cnt_inc;
   logic          held_d, held_q;
   logic          single_d, single_q;
   logic          double_d, double_q;
   logic          long_d, long_q;
   logic          press_d, press_q;
   logic          release_d, release_q;

   edge_detect u_edge (
      .clock (clock),
      .reset (reset),
      .in    (clean),
      .rise  (rise),
      .fall  (fall)
   );

   assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      held_d    = held_q;
      single_d  = 1'b0;
      double_d  = 1'b0;
      long_d    = 1'b0;
      press_d   = rise;
      release_d = fall;
      unique case (state_q)
         ST_IDLE: begin
            if (rise) begin
               cnt_d   = '0;
               state_d = ST_PRESSED;
            end
         end
         ST_PRESSED: begin
            if (fall) begin
               cnt_d   = '0;
               state_d = ST_GAP;
            end else if (clean) begin
               cnt_d = cnt_inc;
               if (cnt_inc == LONG_LAST) begin
                  long_d  = 1'b1;
                  held_d  = 1'b1;
                  state_d = ST_HELD;
               end
            end
         end
         ST_HELD: begin
            if (fall) begin
               held_d  = 1'b0;
               cnt_d   = '0;
               state_d = ST_IDLE;
            end
         end
         ST_GAP: begin
            cnt_d = cnt_inc;
            // A rise on the timeout edge still counts as a double press
            if (rise) begin
               double_d = 1'b1;
               cnt_d    = '0;
               state_d  = ST_SECOND;
            end else if (cnt_inc == DCLK_LAST) begin
               single_d = 1'b1;
               cnt_d    = '0;
               state_d  = ST_IDLE;
            end
         end
         ST_SECOND: begin
            if (fall) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            cnt_d   = '0;
            held_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         held_q    <= 1'b0;
         single_q  <= 1'b0;
         double_q  <= 1'b0;
         long_q    <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         held_q    <= held_d;
         single_q  <= single_d;
         double_q  <= double_d;
         long_q    <= long_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   assign press_edge   = press_q;
   assign release_edge = release_q;
   assign single_press = single_q;
   assign double_press = double_q;
   assign long_press   = long_q;
   assign held         = held_q;
   assign busy         = (state_q != ST_IDLE);

endmodule

// File: doc/button_event.md
BUTTON_EVENT -- requirements
Module: button_event

Interface
REQ-001 Parameter LONG_CYCLES, default 50_000_000, is the continuous high time in clock cycles that qualifies a long press.
REQ-002 Parameter DCLICK_CYCLES, default 12_500_000, is the maximum gap in clock cycles from release to the next press that qualifies a double press.
REQ-003 Port clock, input, 1 bit, is the single system clock; all logic is rising-edge.
REQ-004 Port reset, input, 1 bit, is the asynchronous active-high reset.
REQ-005 Port clean, input, 1 bit, is the debounced button level, already synchronous to clock.
REQ-006 Port press_edge, output, 1 bit, is a one-cycle pulse on each accepted rising edge of clean.
REQ-007 Port release_edge, output, 1 bit, is a one-cycle pulse on each falling edge of clean.
REQ-008 Port single_press, output, 1 bit, is a one-cycle pulse for a short press that is not followed by a second press within the window.
REQ-009 Port double_press, output, 1 bit, is a one-cycle pulse for a second press that starts within the window.
REQ-010 Port long_press, output, 1 bit, is a one-cycle pulse when a hold reaches LONG_CYCLES.
REQ-011 Port held, output, 1 bit, is a level that stays high from the long_press pulse until release.
REQ-012 Port busy, output, 1 bit, is high whenever the state is not IDLE.

Function
REQ-013 The block SHALL register clean into clean_q; a rise is clean=1 with clean_q=0, and a fall is clean=0 with clean_q=1.
REQ-014 All pulse outputs SHALL be registered, asserting the cycle after the clock edge that detects the event, for exactly one cycle.
REQ-015 The state machine SHALL have the states IDLE, PRESSED, HELD, GAP and SECOND.
REQ-016 In IDLE, a rise SHALL clear the counter and move to PRESSED.
REQ-017 In PRESSED, the counter SHALL increment each cycle while clean=1; when the count reaches LONG_CYCLES-1, the block SHALL pulse long_press, set held and move to HELD.
REQ-018 In PRESSED, a fall before the long threshold SHALL clear the counter and move to GAP, with no classification pulse.
REQ-019 In HELD, a fall SHALL clear held and return to IDLE; no single_press or double_press is issued for a long press.
REQ-020 In GAP, the counter SHALL increment each cycle; a rise before the count reaches DCLICK_CYCLES-1 SHALL pulse double_press and move to SECOND.
REQ-021 In GAP, reaching the count DCLICK_CYCLES-1 SHALL pulse single_press and move to IDLE.
REQ-022 If a rise and the GAP timeout occur on the same edge, the rise SHALL win and the block SHALL issue double_press only.
REQ-023 In SECOND, the block SHALL wait for a fall and then return to IDLE; a second press is never promoted to long_press.
REQ-024 press_edge and release_edge SHALL fire on every edge in every state, independent of classification.
REQ-025 The counter width SHALL be $clog2 of the larger of LONG_CYCLES and DCLICK_CYCLES, and the counter SHALL never wrap (it saturates).
REQ-026 At most one of single_press, double_press and long_press SHALL be high in any cycle.

Reset
REQ-027 While reset is high, the state SHALL be IDLE, the counter 0 and all outputs 0.
REQ-028 clean_q SHALL reset to 1, so a button held through reset release produces no press_edge until it has been released and pressed again.
REQ-029 Reset asserted mid-press or mid-gap SHALL abandon the pending classification without emitting any pulse.

Structure
REQ-030 The state encoding and the default parameter values SHALL reside in the shared package button_pkg.
REQ-031 Rise/fall detection SHALL be a sub-module edge_detect (ports clock, reset, in, rise, fall).
REQ-032 The implementation SHALL fit in 120 to 400 lines of RTL.

Verification (bench parameters LONG_CYCLES=8, DCLICK_CYCLES=5)
REQ-033 Short press: clean high 3 cycles, then low 10 cycles -> press_edge once, release_edge once, then single_press 5 cycles after release; no other pulses.
REQ-034 Double press: high 3, low 2, high 3, low -> double_press one cycle after the second rise; single_press never fires.
REQ-035 Long press: clean high 20 cycles -> long_press one cycle after the 8th high cycle; held stays high until the cycle after the fall; no single_press.
REQ-036 Window edge: second rise sampled exactly on the GAP timeout edge -> double_press only (REQ-022); second rise one cycle later -> single_press, then a new PRESSED sequence.
REQ-037 Reset: clean=1 throughout reset deassertion -> no press_edge; a later low-then-high gives a normal press_edge.
REQ-038 Reset during GAP: reset pulse at gap cycle 2 -> all outputs 0, busy=0, and no single_press is ever emitted.
